music_seq_ctrl: RTL
===================

Name: music_seq_ctrl

Overview:
- Sequencer for the music block ROM: 12-bit entries, 16-bit address, registered read with 1-cycle latency behind an enable.
- Walks a song from a CPU-programmed base address and decodes each entry into pitch and duration.
- Drives the note index to the tone generator and times each note in beat units.
- Sits between the CPU register file (start/stop/pause/tempo) and the ROM plus tone generator.

Parameters:
ADDR_WIDTH, 16, ROM address width
DATA_WIDTH, 12, ROM entry width; entry = {pitch[11:4], dur[3:0]}
BEAT_WIDTH, 24, width of the cycles-per-beat tempo value

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start_i  input  1  1-cycle pulse; start or restart the song at base_addr_i
stop_i  input  1  1-cycle pulse; abort playback
pause_i  input  1  level; freeze the note timer while high
base_addr_i  input  ADDR_WIDTH  song start address, sampled on start_i
beat_cycles_i  input  BEAT_WIDTH  clk cycles per duration unit; 0 is treated as 1
rom_en_o  output  1  ROM read enable
rom_addr_o  output  ADDR_WIDTH  ROM read address
rom_data_i  input  DATA_WIDTH  ROM read data, valid the cycle after rom_en_o
note_o  output  8  current pitch index; 0 = rest
note_valid_o  output  1  tone generator enable
busy_o  output  1  high in every state except IDLE
done_o  output  1  1-cycle pulse on song end

Behaviour:
- Reset values: every output 0; state IDLE; pointer, prescaler and duration counters 0.
- States: IDLE, FETCH, LATCH, PLAY.
- IDLE:
  - start_i loads ptr = base_addr_i, then goes to FETCH.
- FETCH (1 cycle):
  - rom_en_o = 1 (decoded from state); rom_addr_o = ptr (registered).
  - Goes to LATCH.
- LATCH (1 cycle): decode rom_data_i.
  - 0xFFF is the end marker: note_valid_o goes to 0, done_o pulses, state goes to IDLE.
  - dur == 0 is a skip entry: ptr+1, back to FETCH, note outputs unchanged.
  - Otherwise: note_o = pitch, note_valid_o = (pitch != 0); load dur counter = dur and prescaler = max(beat_cycles_i,1)-1; go to PLAY.
- PLAY:
  - The prescaler decrements each cycle. At 0 it reloads and the dur counter decrements.
  - When dur reaches 0 with the prescaler at 0: ptr+1, go to FETCH.
  - note_o and note_valid_o hold through FETCH/LATCH, so there is no glitch between notes.
- Latency: start_i sampled at edge E0, rom_en_o high in the following cycle, note_valid_o high after E2.
- Note time on the line: dur × max(beat_cycles_i,1) cycles in PLAY, plus 2 cycles of fetch overhead before the next note.
- beat_cycles_i is sampled only at LATCH and at prescaler reload; changing it mid-note takes effect at the next beat.
- pause_i:
  - In PLAY, freezes the prescaler and dur counter; note_valid_o is forced to 0 while paused, and note_o is held.
  - In FETCH/LATCH it has no effect; pausing occurs on entry to PLAY.
- stop_i, any state: next cycle is IDLE, note_valid_o = 0, note_o = 0, no done_o pulse.
- start_i while busy: restart from the new base_addr_i (go to FETCH, note_valid_o = 0).
- start_i and stop_i in the same cycle: stop wins.
- Pointer wrap: if ptr = 2^ADDR_WIDTH-1 and the note completes, treat it as the end marker (done_o pulse, IDLE). There is no wrap to 0.

Optional Feature:
- Macro MUSIC_SEQ_LOOP_EN.
- Defined: adds input loop_i (1 bit). At an end marker or address-max end with loop_i = 1, ptr reloads the base address latched at start, goes to FETCH, done_o pulses, and busy_o stays 1. loop_i = 0 behaves as without the macro.
- Undefined: no loop_i port; the song always ends to IDLE.

Decomposition:
- Package music_pkg holds:
  - state enum (IDLE/FETCH/LATCH/PLAY)
  - END_MARKER = 12'hFFF
  - field positions PITCH_MSB/LSB = 11/4 and DUR_MSB/LSB = 3/0
  - REST_PITCH = 0
- One sub-module: music_beat_timer, holding the prescaler plus duration down-counter.
  - Inputs: load, dur, beat_cycles, hold.
  - Output: expire pulse.

Test Plan:
- ROM {0x3A2, 0x101, 0xFFF}, base 0, beat_cycles 4, start: note 0x3A for 8 cycles, 2 overhead cycles, note 0x10 for 4 cycles, then done_o pulse, busy_o=0; rom_addr sequence 0,1,2.
- Entry 0x002 (rest) with beat_cycles 3: note_valid_o=0 for 6 cycles, note_o=0.
- Skip entry 0x550 between notes: no change on note_o, ptr skips, 1 extra FETCH/LATCH pair only.
- pause_i high 10 cycles mid-note on 0x3A2/beat 4: note_valid_o low for those 10 cycles; total PLAY time = 18 cycles.
- stop_i mid-PLAY, and start_i+stop_i together: IDLE next cycle, outputs 0, no done_o; rst_n low mid-PLAY clears all outputs asynchronously.
- MUSIC_SEQ_LOOP_EN with loop_i=1, base 0x0100, ROM {0x3A1, 0xFFF}: addresses 0x100, 0x101, 0x100, …; done_o pulse each pass; busy_o stays 1. Base at 0xFFFF with note 0x201: end after one note.

Source files
------------

// File: rtl/music_pkg.sv
// music_pkg: shared constants for the music ROM sequencer.
// State codes, ROM entry field positions, end marker and rest pitch.
package music_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_FETCH = 2'd1;
   localparam state_t S_LATCH = 2'd2;
   localparam state_t S_PLAY  = 2'd3;

   localparam logic [11:0] END_MARKER = 12'hFFF;

   localparam int PITCH_MSB = 11;
   localparam int PITCH_LSB = 4;
   localparam int DUR_MSB   = 3;
   localparam int DUR_LSB   = 0;

   localparam logic [7:0] REST_PITCH = 8'h00;

endpackage

// File: rtl/music_beat_timer.sv
// music_beat_timer: beat prescaler plus note-duration down-counter.
// Ports: load/dur/beat_cycles start a note, hold freezes, expire pulses.
module music_beat_timer
#(
   parameter int BEAT_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [3:0]            dur,
   input  logic [BEAT_WIDTH-1:0] beat_cycles,
   input  logic                  hold,
   output logic                  expire
);

   logic [BEAT_WIDTH-1:0] pre_q;
   logic [BEAT_WIDTH-1:0] reload;
   logic [3:0]            dur_q;

   // a zero tempo behaves as one cycle per beat
   assign reload = (beat_cycles == '0) ? '0
                 : beat_cycles - BEAT_WIDTH'(1);

   // last beat of the note ends on this edge
   assign expire = !load && !hold
                && (pre_q == '0) && (dur_q == 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         dur_q <= '0;
      end else if (load) begin
         pre_q <= reload;
         dur_q <= dur;
      end else if (!hold && dur_q != 4'd0) begin
         if (pre_q == '0) begin
            pre_q <= reload;
            dur_q <= dur_q - 4'd1;
         end else begin
            pre_q <= pre_q - BEAT_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/music_seq_ctrl.sv
// music_seq_ctrl: walks a song in the music ROM and drives the tone gen.
// Ports: start/stop/pause/base/tempo in, ROM en/addr/data, note/valid,
// busy, done. Optional MUSIC_SEQ_LOOP_EN adds loop_i (replay on end).
module music_seq_ctrl
   import music_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 12,
   parameter int BEAT_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic                  pause_i,
`ifdef MUSIC_SEQ_LOOP_EN
   input  logic                  loop_i,
`endif
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [BEAT_WIDTH-1:0] beat_cycles_i,
   output logic                  rom_en_o,
   output logic [ADDR_WIDTH-1:0] rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_data_i,
   output logic [7:0]            note_o,
   output logic                  note_valid_o,
   output logic                  busy_o,
   output logic                  done_o
);

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] ptr_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [7:0]            note_q;
   logic                  nv_q;
   logic                  done_q;

   logic [7:0] pitch;
   logic [3:0] dur;
   logic       in_latch;
   logic       in_play;
   logic       is_end;
   logic       is_skip;
   logic       expire;
   logic       advance;
   logic       end_song;
   logic       loop_on;

`ifdef MUSIC_SEQ_LOOP_EN
   assign loop_on = loop_i;
`else
   assign loop_on = 1'b0;
`endif

   assign pitch    = rom_data_i[PITCH_MSB:PITCH_LSB];
   assign dur      = rom_data_i[DUR_MSB:DUR_LSB];
   assign in_latch = (state_q == S_LATCH);
   assign in_play  = (state_q == S_PLAY);
   assign is_end   = in_latch
                  && (rom_data_i == DATA_WIDTH'(END_MARKER));
   assign is_skip  = in_latch && !is_end && (dur == 4'd0);
   assign advance  = is_skip || (in_play && expire);
   // stepping past the top address ends the song instead of wrapping
   assign end_song = is_end || (advance && (&ptr_q));

   music_beat_timer #(
      .BEAT_WIDTH (BEAT_WIDTH)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (in_latch && !is_end && !is_skip),
      .dur         (dur),
      .beat_cycles (beat_cycles_i),
      .hold        (!in_play || pause_i),
      .expire      (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         base_q  <= '0;
         note_q  <= '0;
         nv_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (stop_i) begin
            state_q <= S_IDLE;
            note_q  <= '0;
            nv_q    <= 1'b0;
         end else if (start_i) begin
            ptr_q   <= base_addr_i;
            base_q  <= base_addr_i;
            nv_q    <= 1'b0;
            state_q <= S_FETCH;
         end else if (end_song) begin
            done_q <= 1'b1;
            nv_q   <= 1'b0;
            if (loop_on) begin
               ptr_q   <= base_q;
               state_q <= S_FETCH;
            end else begin
               state_q <= S_IDLE;
            end
         end else if (advance) begin
            ptr_q   <= ptr_q + ADDR_WIDTH'(1);
            state_q <= S_FETCH;
         end else begin
            unique case (state_q)
               S_FETCH: state_q <= S_LATCH;
               S_LATCH: begin
                  note_q  <= pitch;
                  nv_q    <= (pitch != REST_PITCH);
                  state_q <= S_PLAY;
               end
               default: ;
            endcase
         end
      end
   end

   assign rom_en_o     = (state_q == S_FETCH);
   assign rom_addr_o   = ptr_q;
   assign note_o       = note_q;
   // tone is muted while paused but the pitch is kept
   assign note_valid_o = nv_q && !(in_play && pause_i);
   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = done_q;

endmodule
